// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmitter between a CPU char FIFO and a monitor stream
module uart_tx_arbiter #(
  parameter int CPU_FIFO_DEPTH = 4,
  parameter int LOCK_MAX       = 64,
  parameter int IDLE_TO        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_we,
  input  logic [7:0] cpu_char,
  output logic       cpu_fifo_full,
  output logic       cpu_ovf,
  input  logic       cpu_ovf_clr,
  input  logic       mon_valid,
  input  logic [7:0] mon_char,
  output logic       mon_ready,
  output logic [7:0] uart_io_char,
  output logic       uart_io_we,
  input  logic       uart_io_full,
  output logic [1:0] arb_owner
);

  localparam int AW = (CPU_FIFO_DEPTH > 1) ? $clog2(CPU_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(CPU_FIFO_DEPTH + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam int IW = $clog2(IDLE_TO + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CPU  = 2'd1,
    S_MON  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_mon_q, last_mon_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;

  logic [7:0]    fifo_mem_q [CPU_FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          cpu_ovf_q;
  logic          uart_io_we_q;
  logic [7:0]    uart_io_char_q;

  logic       fifo_empty, fifo_full;
  logic       issue_ok, cpu_pop, mon_xfer, issue;
  logic       cpu_push, ovf_set, owner_data, cpu_req, release_gnt;
  logic [7:0] issue_char;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(CPU_FIFO_DEPTH));

  // Transmitter free and at least one idle cycle since the previous pulse.
  assign issue_ok   = ~uart_io_full & ~uart_io_we_q;
  assign cpu_pop    = (state_q == S_CPU) & ~fifo_empty & issue_ok;
  assign mon_ready  = rst_n & (state_q == S_MON) & issue_ok;
  assign mon_xfer   = mon_valid & mon_ready;
  assign issue      = cpu_pop | mon_xfer;
  assign issue_char = cpu_pop ? fifo_mem_q[rd_ptr_q] : mon_char;

  // A pop in the same cycle frees the slot, so a write into a full FIFO is not lost.
  assign cpu_push   = cpu_we & (~fifo_full | cpu_pop);
  assign ovf_set    = cpu_we & fifo_full & ~cpu_pop;

  assign owner_data = ((state_q == S_CPU) & ~fifo_empty) | ((state_q == S_MON) & mon_valid);
  // A write arriving this cycle counts as a CPU request so simultaneous arrivals honour round robin.
  assign cpu_req    = ~fifo_empty | cpu_we;

  assign cpu_fifo_full = fifo_full;
  assign cpu_ovf       = cpu_ovf_q;
  assign uart_io_we    = uart_io_we_q;
  assign uart_io_char  = uart_io_char_q;
  assign arb_owner     = state_q;

  // Character storage; contents need no reset because pointers/count define validity.
  always_ff @(posedge clk) begin
    if (cpu_push) fifo_mem_q[wr_ptr_q] <= cpu_char;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      cpu_ovf_q <= 1'b0;
    end else begin
      if (cpu_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (cpu_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (cpu_push && !cpu_pop)      count_q <= count_q + CW'(1);
      else if (cpu_pop && !cpu_push) count_q <= count_q - CW'(1);
      if (ovf_set)          cpu_ovf_q <= 1'b1;
      else if (cpu_ovf_clr) cpu_ovf_q <= 1'b0;
    end
  end

  // Arbiter state, grant counters and registered transmitter outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      last_mon_q     <= 1'b1;
      lock_cnt_q     <= '0;
      idle_cnt_q     <= '0;
      uart_io_we_q   <= 1'b0;
      uart_io_char_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      last_mon_q   <= last_mon_d;
      lock_cnt_q   <= lock_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      uart_io_we_q <= issue;
      if (issue) uart_io_char_q <= issue_char;
    end
  end

  // Grant selection and release: newline, lock limit or owner idle timeout.
  always_comb begin
    state_d     = state_q;
    last_mon_d  = last_mon_q;
    lock_cnt_d  = lock_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    release_gnt = 1'b0;
    case (state_q)
      S_IDLE: begin
        lock_cnt_d = '0;
        idle_cnt_d = '0;
        if (cpu_req && mon_valid) state_d = last_mon_q ? S_CPU : S_MON;
        else if (cpu_req)         state_d = S_CPU;
        else if (mon_valid)       state_d = S_MON;
      end
      S_CPU, S_MON: begin
        if (issue) begin
          lock_cnt_d = lock_cnt_q + LW'(1);
          if (issue_char == 8'h0A || lock_cnt_q == LW'(LOCK_MAX - 1)) release_gnt = 1'b1;
        end
        // A stalled transmitter freezes the idle count so the grant is held.
        if (owner_data) begin
          idle_cnt_d = '0;
        end else if (!uart_io_full) begin
          if (idle_cnt_q == IW'(IDLE_TO - 1)) release_gnt = 1'b1;
          else idle_cnt_d = idle_cnt_q + IW'(1);
        end
        if (release_gnt) begin
          state_d    = S_IDLE;
          last_mon_d = (state_q == S_MON);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_we;
  logic [7:0] cpu_char;
  logic       cpu_fifo_full;
  logic       cpu_ovf;
  logic       cpu_ovf_clr;
  logic       mon_valid;
  logic [7:0] mon_char;
  logic       mon_ready;
  logic [7:0] uart_io_char;
  logic       uart_io_we;
  logic       uart_io_full;
  logic [1:0] arb_owner;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] log_char[$];
  int         log_cyc[$];
  logic [1:0] log_own[$];
  logic [1:0] grant_log[$];
  logic [1:0] prev_owner = 2'd0;

  uart_tx_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_we       (cpu_we),
    .cpu_char     (cpu_char),
    .cpu_fifo_full(cpu_fifo_full),
    .cpu_ovf      (cpu_ovf),
    .cpu_ovf_clr  (cpu_ovf_clr),
    .mon_valid    (mon_valid),
    .mon_char     (mon_char),
    .mon_ready    (mon_ready),
    .uart_io_char (uart_io_char),
    .uart_io_we   (uart_io_we),
    .uart_io_full (uart_io_full),
    .arb_owner    (arb_owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every transmitter pulse and every new grant, sampled mid-cycle.
  always @(negedge clk) begin
    if (uart_io_we === 1'b1) begin
      log_char.push_back(uart_io_char);
      log_cyc.push_back(cyc);
      log_own.push_back(arb_owner);
    end
    if (arb_owner !== prev_owner) begin
      if (arb_owner != 2'd0) grant_log.push_back(arb_owner);
      prev_owner = arb_owner;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] char_at(input int i);
    if (i < log_char.size()) return log_char[i];
    return 8'hxx;
  endfunction

  function automatic logic [1:0] grant_at(input int i);
    if (i < grant_log.size()) return grant_log[i];
    return 2'bxx;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    cpu_we = 1'b0; cpu_char = 8'h00; cpu_ovf_clr = 1'b0;
    mon_valid = 1'b0; mon_char = 8'h00; uart_io_full = 1'b0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    log_char.delete(); log_cyc.delete(); log_own.delete(); grant_log.delete();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (arb_owner != 2'd0 && n < budget) begin step(1); n++; end
    check_eq(tag, 32'(arb_owner), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int idx;
    logic hs;
    int snap;
    logic [7:0] exp_c [6];

    // Reset values while reset is asserted.
    quiet_inputs();
    rst_n = 1'b0;
    step(2);
    check_eq("rst_full", 32'(cpu_fifo_full), 32'd0);
    check_eq("rst_ovf", 32'(cpu_ovf), 32'd0);
    check_eq("rst_owner", 32'(arb_owner), 32'd0);
    check_eq("rst_we", 32'(uart_io_we), 32'd0);
    check_eq("rst_char", 32'(uart_io_char), 32'd0);
    check_eq("rst_mon_ready", 32'(mon_ready), 32'd0);

    // CPU sends "AB\n".
    do_reset();
    cpu_we = 1'b1;
    cpu_char = 8'h41; step(1);
    cpu_char = 8'h42; step(1);
    cpu_char = 8'h0A; step(1);
    cpu_we = 1'b0;
    n = 0;
    while (log_char.size() < 3 && n < 40) begin step(1); n++; end
    wait_idle("ab_release", 40);
    check_eq("ab_count", 32'(log_char.size()), 32'd3);
    check_eq("ab_c0", 32'(char_at(0)), 32'h41);
    check_eq("ab_c1", 32'(char_at(1)), 32'h42);
    check_eq("ab_c2", 32'(char_at(2)), 32'h0A);
    if (log_cyc.size() >= 3) begin
      check_eq("ab_gap01", 32'(log_cyc[1] - log_cyc[0] >= 2), 32'd1);
      check_eq("ab_gap12", 32'(log_cyc[2] - log_cyc[1] >= 2), 32'd1);
      check_eq("ab_owner_first", 32'(log_own[0]), 32'd1);
      check_eq("ab_owner_after_nl", 32'(log_own[2]), 32'd0);
    end

    // Simultaneous requests from reset: CPU, monitor, CPU, monitor.
    do_reset();
    mon_char = 8'h0A;
    mon_valid = 1'b1;
    for (int k = 0; k < 300 && grant_log.size() < 4; k++) begin
      cpu_we = (k < 4);
      cpu_char = (k == 0) ? 8'h78 : (k == 2) ? 8'h79 : 8'h0A;
      step(1);
    end
    cpu_we = 1'b0;
    mon_valid = 1'b0;
    wait_idle("rr_release", 60);
    check_eq("rr_g0", 32'(grant_at(0)), 32'd1);
    check_eq("rr_g1", 32'(grant_at(1)), 32'd2);
    check_eq("rr_g2", 32'(grant_at(2)), 32'd1);
    check_eq("rr_g3", 32'(grant_at(3)), 32'd2);
    exp_c[0] = 8'h78; exp_c[1] = 8'h0A; exp_c[2] = 8'h0A;
    exp_c[3] = 8'h79; exp_c[4] = 8'h0A; exp_c[5] = 8'h0A;
    for (int i = 0; i < 5; i++) check_eq($sformatf("rr_c%0d", i), 32'(char_at(i)), 32'(exp_c[i]));

    // Overflow with transmitter full, then push+pop while full.
    do_reset();
    uart_io_full = 1'b1;
    cpu_we = 1'b1;
    for (int i = 0; i < 5; i++) begin cpu_char = 8'h61 + 8'(i); step(1); end
    cpu_we = 1'b0;
    step(1);
    check_eq("ovf_full", 32'(cpu_fifo_full), 32'd1);
    check_eq("ovf_flag", 32'(cpu_ovf), 32'd1);
    check_eq("ovf_owner_held", 32'(arb_owner), 32'd1);
    cpu_ovf_clr = 1'b1; step(1); cpu_ovf_clr = 1'b0;
    check_eq("ovf_clr", 32'(cpu_ovf), 32'd0);
    uart_io_full = 1'b0;
    cpu_we = 1'b1; cpu_char = 8'h66; step(1); cpu_we = 1'b0;
    check_eq("pushpop_full", 32'(cpu_fifo_full), 32'd1);
    check_eq("pushpop_no_ovf", 32'(cpu_ovf), 32'd0);
    wait_idle("ovf_release", 80);
    check_eq("ovf_count", 32'(log_char.size()), 32'd5);
    exp_c[0] = 8'h61; exp_c[1] = 8'h62; exp_c[2] = 8'h63; exp_c[3] = 8'h64; exp_c[4] = 8'h66;
    for (int i = 0; i < 5; i++) check_eq($sformatf("ovf_c%0d", i), 32'(char_at(i)), 32'(exp_c[i]));
    uart_io_full = 1'b1;
    cpu_we = 1'b1;
    for (int i = 0; i < 5; i++) begin cpu_char = 8'h67; step(1); end
    cpu_ovf_clr = 1'b1; step(1);
    cpu_ovf_clr = 1'b0; cpu_we = 1'b0;
    check_eq("ovf_beats_clr", 32'(cpu_ovf), 32'd1);

    // Monitor lock limit: 64 characters, then CPU, then remaining monitor characters.
    do_reset();
    idx = 0;
    for (int k = 0; k < 400 && idx < 70; k++) begin
      mon_char = 8'h20 + 8'(idx);
      mon_valid = 1'b1;
      cpu_we = (k == 4 || k == 5);
      cpu_char = (k == 4) ? 8'h5A : 8'h0A;
      @(negedge clk);
      hs = mon_valid & mon_ready;
      step(1);
      if (hs) idx++;
    end
    mon_valid = 1'b0;
    cpu_we = 1'b0;
    wait_idle("lock_release", 60);
    check_eq("lock_count", 32'(log_char.size()), 32'd72);
    check_eq("lock_first", 32'(char_at(0)), 32'h20);
    check_eq("lock_last_mon", 32'(char_at(63)), 32'h5F);
    check_eq("lock_cpu_c0", 32'(char_at(64)), 32'h5A);
    check_eq("lock_cpu_c1", 32'(char_at(65)), 32'h0A);
    check_eq("lock_mon_resume", 32'(char_at(66)), 32'h60);
    check_eq("lock_mon_end", 32'(char_at(71)), 32'h65);
    check_eq("lock_g0", 32'(grant_at(0)), 32'd2);
    check_eq("lock_g1", 32'(grant_at(1)), 32'd1);
    check_eq("lock_g2", 32'(grant_at(2)), 32'd2);

    // Idle timeout after a stall that must not advance the idle count.
    do_reset();
    mon_valid = 1'b1;
    mon_char = 8'h71;
    hs = 1'b0;
    for (int k = 0; k < 20 && !hs; k++) begin
      @(negedge clk);
      hs = mon_valid & mon_ready;
      step(1);
    end
    check_eq("to_handshake", 32'(hs), 32'd1);
    mon_valid = 1'b0;
    uart_io_full = 1'b1;
    step(30);
    check_eq("to_stall_hold", 32'(arb_owner), 32'd2);
    uart_io_full = 1'b0;
    n = 0;
    while (arb_owner == 2'd2 && n < 100) begin step(1); n++; end
    check_eq("to_cycles", 32'(n), 32'd16);
    check_eq("to_owner", 32'(arb_owner), 32'd0);

    // Reset in the middle of a monitor grant with CPU characters queued.
    do_reset();
    mon_valid = 1'b1;
    mon_char = 8'h6D;
    n = 0;
    while (arb_owner != 2'd2 && n < 10) begin step(1); n++; end
    cpu_we = 1'b1;
    for (int i = 0; i < 3; i++) begin cpu_char = 8'h72 + 8'(i); step(1); end
    cpu_we = 1'b0;
    step(1);
    check_eq("mr_owner_pre", 32'(arb_owner), 32'd2);
    rst_n = 1'b0;
    step(1);
    check_eq("mr_full", 32'(cpu_fifo_full), 32'd0);
    check_eq("mr_ovf", 32'(cpu_ovf), 32'd0);
    check_eq("mr_owner", 32'(arb_owner), 32'd0);
    check_eq("mr_we", 32'(uart_io_we), 32'd0);
    check_eq("mr_char", 32'(uart_io_char), 32'd0);
    check_eq("mr_mon_ready", 32'(mon_ready), 32'd0);
    snap = log_char.size();
    mon_valid = 1'b0;
    rst_n = 1'b1;
    step(12);
    check_eq("mr_no_pulse", 32'(log_char.size()), 32'(snap));
    check_eq("mr_owner_after", 32'(arb_owner), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter CPU_FIFO_DEPTH, default 4, depth of the CPU character FIFO (power of 2, 2..16).
REQ-002 SHALL have parameter LOCK_MAX, default 64, maximum characters sent per grant.
REQ-003 SHALL have parameter IDLE_TO, default 16, number of owner-idle cycles before a grant is released.
REQ-004 SHALL have port clk, input, 1 bit, single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-006 SHALL have port cpu_we, input, 1 bit, CPU character write strobe from the IO register block.
REQ-007 SHALL have port cpu_char, input, 8 bits, CPU character, valid with cpu_we.
REQ-008 SHALL have port cpu_fifo_full, output, 1 bit, CPU FIFO full; readable by software as a poll bit.
REQ-009 SHALL have port cpu_ovf, output, 1 bit, sticky flag: a CPU write was dropped.
REQ-010 SHALL have port cpu_ovf_clr, input, 1 bit, clears cpu_ovf.
REQ-011 SHALL have port mon_valid, input, 1 bit, monitor character valid.
REQ-012 SHALL have port mon_char, input, 8 bits, monitor character.
REQ-013 SHALL have port mon_ready, output, 1 bit, monitor character accepted this cycle when mon_valid is also high.
REQ-014 SHALL have port uart_io_char, output, 8 bits, character to the UART transmitter.
REQ-015 SHALL have port uart_io_we, output, 1 bit, one-cycle write pulse to the UART transmitter.
REQ-016 SHALL have port uart_io_full, input, 1 bit, UART transmitter busy/full.
REQ-017 SHALL have port arb_owner, output, 2 bits, current grant: 0 = none, 1 = CPU, 2 = monitor.

Function
REQ-018 CPU FIFO push SHALL occur on cpu_we & ~cpu_fifo_full; push while full with no same-cycle pop SHALL drop the character and set cpu_ovf.
REQ-019 Push and pop in the same cycle while full SHALL accept the push; occupancy stays full and there is no overflow.
REQ-020 cpu_ovf_clr SHALL clear cpu_ovf; a same-cycle overflow SHALL win and leave cpu_ovf set.
REQ-021 The arbiter SHALL be an FSM with states IDLE, CPU_GNT and MON_GNT; arb_owner SHALL encode the state as 0, 1 and 2.
REQ-022 From IDLE with exactly one requester (CPU FIFO non-empty, or mon_valid), the FSM SHALL move to that requester's grant on the next cycle.
REQ-023 From IDLE with both requesting, the FSM SHALL grant the requester that is not last_owner (round-robin); last_owner resets to monitor, so CPU wins first.
REQ-024 In a grant state, a character SHALL issue when the owner has data, ~uart_io_full, and uart_io_we was low in the previous cycle (minimum one-cycle gap between pulses).
REQ-025 On issue, uart_io_char SHALL load the character and uart_io_we SHALL pulse for one cycle on the next edge: one-cycle latency from FIFO pop or monitor handshake.
REQ-026 mon_ready SHALL be combinational and high only in MON_GNT under the REQ-024 conditions; a monitor transfer is mon_valid & mon_ready.
REQ-027 In CPU_GNT the FIFO head SHALL pop on issue; no character SHALL ever be issued from the non-owner.
REQ-028 A grant SHALL return to IDLE after issuing 0x0A, after LOCK_MAX characters, or after IDLE_TO consecutive cycles with no owner data; last_owner SHALL update on release.
REQ-029 The grant character counter and idle counter SHALL reset to 0 on each entry to a grant; the idle counter SHALL reset on any owner data.
REQ-030 uart_io_full high SHALL stall issue indefinitely without advancing the idle counter; the grant SHALL be held.
REQ-031 uart_io_char SHALL hold its last value between pulses.

Reset
REQ-032 While rst_n is low at a clock edge, the block SHALL apply: FIFO empty, cpu_fifo_full=0, cpu_ovf=0, FSM=IDLE, arb_owner=0, last_owner=monitor, uart_io_we=0, uart_io_char=0x00, mon_ready=0, counters 0.
REQ-033 Reset mid-grant SHALL discard FIFO contents and any un-issued character; no uart_io_we SHALL occur in the cycle after reset is sampled.

Verification
REQ-034 CPU writes "AB\n" with uart_io_full=0 -> uart_io_we pulses carry 0x41, 0x42, 0x0A at least 2 cycles apart; arb_owner goes 1, then 0 after 0x0A.
REQ-035 cpu_we and mon_valid rise in the same cycle from reset -> CPU granted first; the monitor is granted after the CPU newline; both then request again -> monitor granted.
REQ-036 Five CPU writes with uart_io_full=1 (depth 4) -> cpu_fifo_full=1, cpu_ovf=1, 4 characters are sent after full drops, and the fifth is lost.
REQ-037 Monitor streams 70 non-newline characters while CPU requests -> release after 64 characters, CPU granted next.
REQ-038 Monitor is granted, then mon_valid drops for 16 cycles -> arb_owner returns to 0 on IDLE_TO expiry.
REQ-039 rst_n pulled low in MON_GNT with 3 characters in the CPU FIFO -> all outputs at REQ-032 values and no further uart_io_we.
